// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI slave register file
//
// Purpose: FSM state enumeration, address/data widths, command byte bit
// positions and the device-ID register address.
package spi_pkg;

  localparam int ADDR_W     = 6;
  localparam int DATA_W     = 8;
  localparam int CMD_RW_BIT = 7;
  localparam int CMD_MB_BIT = 6;

  localparam logic [ADDR_W-1:0] DEVID_ADDR = 6'h00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_RDATA,
    ST_WDATA
  } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop synchronizer with level and edge pulses
//
// Purpose: brings an asynchronous pin into the i_clk domain and flags its
// rising/falling edges. Edge pulses come from the last sync stage versus one
// extra history flop, so an action taken on a pulse lands SYNC_STAGES+1
// clocks after the pin changed.
// Ports:
//   i_clk, i_reset  system clock, synchronous active-high reset
//   i_d             asynchronous input
//   o_level         synchronized level
//   o_rise, o_fall  one-clock edge pulses
import spi_pkg::*;

module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync <= {SYNC_STAGES{RESET_VAL}};
      r_prev <= RESET_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = o_level & ~r_prev;
  assign o_fall  = ~o_level & r_prev;

endmodule

// File: rtl/spi_slave_regfile.sv
// rtl/spi_slave_regfile.sv - SPI mode-3 slave in front of a 64x8 register file
//
// Purpose: command byte {RW, MB, ADDR[5:0]} followed by data bytes; reads
// shift reg[ADDR] out on MISO, writes commit into the register file and are
// reported on wr_valid/wr_addr/wr_data. Register 0x00 holds DEVID, read-only.
// Optional feature: define SPI_SLAVE_AUTOINC_EN to advance ADDR after each
// data byte when MB=1; without it ADDR never moves.
// Ports:
//   i_clk, i_reset              system clock (>= 8x SCLK), sync active-high reset
//   i_sclk, i_cs, i_mosi        SPI pins (async)
//   o_miso, o_miso_oe           serial data out and pad enable
//   i_host_we/addr/wdata        host-side register write port
//   o_wr_valid/addr/data        committed SPI write report
//   o_xfer_done                 pulse after chip select deasserts
import spi_pkg::*;

module spi_slave_regfile #(
  parameter logic [7:0] DEVID       = 8'hE5,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_sclk,
  input  logic        i_cs,
  input  logic        i_mosi,
  output logic        o_miso,
  output logic        o_miso_oe,
  input  logic        i_host_we,
  input  logic [5:0]  i_host_addr,
  input  logic [7:0]  i_host_wdata,
  output logic        o_wr_valid,
  output logic [5:0]  o_wr_addr,
  output logic [7:0]  o_wr_data,
  output logic        o_xfer_done
);

  logic w_sclk_level, w_sclk_rise, w_sclk_fall;
  logic w_cs_level, w_cs_rise, w_cs_fall;
  logic w_mosi_level, w_mosi_rise, w_mosi_fall;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sclk (
    .i_clk(i_clk), .i_reset(i_reset), .i_d(i_sclk),
    .o_level(w_sclk_level), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall));
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .i_clk(i_clk), .i_reset(i_reset), .i_d(i_cs),
    .o_level(w_cs_level), .o_rise(w_cs_rise), .o_fall(w_cs_fall));
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .i_clk(i_clk), .i_reset(i_reset), .i_d(i_mosi),
    .o_level(w_mosi_level), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall));

  spi_state_t              r_state, w_state_next;
  logic [2:0]              r_bit_cnt;
  logic [DATA_W-1:0]       r_shift;
  logic [DATA_W-1:0]       r_tx;
  logic [ADDR_W-1:0]       r_addr;
  logic                    r_mb;
  logic                    r_miso;
  logic [DATA_W-1:0]       r_regs [0:(1<<ADDR_W)-1];
  logic                    r_wr_valid;
  logic [ADDR_W-1:0]       r_wr_addr;
  logic [DATA_W-1:0]       r_wr_data;
  logic                    r_xfer_done;
  logic [2:0]              r_settle;
  logic                    r_armed;

  logic [DATA_W-1:0]       w_rx_byte;
  logic                    w_byte_end;
  logic                    w_inc;
  logic [ADDR_W-1:0]       w_next_addr;

  assign w_rx_byte  = {r_shift[DATA_W-2:0], w_mosi_level};
  assign w_byte_end = w_sclk_rise && (r_bit_cnt == 3'd7);

`ifdef SPI_SLAVE_AUTOINC_EN
  assign w_inc = r_mb;
`else
  assign w_inc = 1'b0;
`endif
  // 6-bit add wraps 0x3F -> 0x00 on its own
  assign w_next_addr = r_addr + ADDR_W'(w_inc);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_cs_fall && r_armed) w_state_next = ST_CMD;
      ST_CMD:   if (w_byte_end)
                  w_state_next = w_rx_byte[CMD_RW_BIT] ? ST_RDATA : ST_WDATA;
      default:  w_state_next = r_state;
    endcase
    if (w_cs_rise) w_state_next = ST_IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_tx        <= '0;
      r_addr      <= '0;
      r_mb        <= 1'b0;
      r_miso      <= 1'b0;
      r_wr_valid  <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_xfer_done <= 1'b0;
      r_settle    <= '0;
      r_armed     <= 1'b0;
      for (int i = 0; i < (1 << ADDR_W); i++) r_regs[i] <= '0;
      r_regs[DEVID_ADDR] <= DEVID;
    end else begin
      r_wr_valid  <= 1'b0;
      r_xfer_done <= w_cs_rise;

      // The sync chain resets to "CS high", so a CS held low across reset
      // shows up as a fake fall. Only arm once the chain holds real samples
      // and CS has been seen high.
      if (r_settle != 3'(SYNC_STAGES)) r_settle <= r_settle + 3'd1;
      else if (w_cs_level)             r_armed  <= 1'b1;

      if (i_host_we && (i_host_addr != DEVID_ADDR)) r_regs[i_host_addr] <= i_host_wdata;

      // Later SPI commit in this block overrides a same-address host write
      if (!w_cs_rise) begin
        case (r_state)
          ST_IDLE: begin
            if (w_state_next == ST_CMD) begin
              r_bit_cnt <= '0;
              r_shift   <= '0;
            end
          end
          ST_CMD: begin
            if (w_sclk_rise) begin
              r_shift   <= w_rx_byte;
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                r_addr <= w_rx_byte[ADDR_W-1:0];
                r_mb   <= w_rx_byte[CMD_MB_BIT];
                r_tx   <= r_regs[w_rx_byte[ADDR_W-1:0]];
                r_miso <= 1'b0;
              end
            end
          end
          ST_RDATA: begin
            if (w_sclk_fall) begin
              r_miso <= r_tx[DATA_W-1];
              r_tx   <= {r_tx[DATA_W-2:0], 1'b0};
            end
            if (w_sclk_rise) begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                r_addr <= w_next_addr;
                r_tx   <= r_regs[w_next_addr];
              end
            end
          end
          ST_WDATA: begin
            if (w_sclk_rise) begin
              r_shift   <= w_rx_byte;
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                if (r_addr != DEVID_ADDR) r_regs[r_addr] <= w_rx_byte;
                r_wr_valid <= 1'b1;
                r_wr_addr  <= r_addr;
                r_wr_data  <= w_rx_byte;
                r_addr     <= w_next_addr;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_miso_oe   = (r_state == ST_RDATA) && !w_cs_level;
  assign o_miso      = r_miso & o_miso_oe;
  assign o_wr_valid  = r_wr_valid;
  assign o_wr_addr   = r_wr_addr;
  assign o_wr_data   = r_wr_data;
  assign o_xfer_done = r_xfer_done;

endmodule

// File: tb/tb_spi_slave_regfile.sv
// tb/tb_spi_slave_regfile.sv - directed self-checking bench for spi_slave_regfile
module tb_spi_slave_regfile;

  logic       clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_sclk = 1'b1;
  logic       i_cs = 1'b1;
  logic       i_mosi = 1'b0;
  logic       o_miso, o_miso_oe;
  logic       i_host_we = 1'b0;
  logic [5:0] i_host_addr = '0;
  logic [7:0] i_host_wdata = '0;
  logic       o_wr_valid;
  logic [5:0] o_wr_addr;
  logic [7:0] o_wr_data;
  logic       o_xfer_done;

  int vectors = 0;
  int miscompares = 0;

  int         wr_cnt = 0;
  int         xfer_cnt = 0;
  logic [5:0] last_wr_addr = '0;
  logic [7:0] last_wr_data = '0;

  logic [7:0] rd_buf [8];
  logic       oe_cmd_any;
  logic       oe_data_all;

  spi_slave_regfile dut (
    .i_clk(clk), .i_reset(i_reset), .i_sclk(i_sclk), .i_cs(i_cs), .i_mosi(i_mosi),
    .o_miso(o_miso), .o_miso_oe(o_miso_oe),
    .i_host_we(i_host_we), .i_host_addr(i_host_addr), .i_host_wdata(i_host_wdata),
    .o_wr_valid(o_wr_valid), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
    .o_xfer_done(o_xfer_done));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_wr_valid) begin
      wr_cnt++;
      last_wr_addr = o_wr_addr;
      last_wr_data = o_wr_data;
    end
    if (o_xfer_done) xfer_cnt++;
  end

  task automatic spi_begin();
    @(negedge clk) i_cs = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic spi_end();
    @(negedge clk) i_cs = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  // Mode 3: drive MOSI on the falling SCLK edge, sample MISO just before rising
  task automatic spi_bits(input logic [7:0] d, input int n,
                          output logic [7:0] rx, output logic oe_all, output logic oe_any);
    rx = '0; oe_all = 1'b1; oe_any = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      i_sclk = 1'b0;
      i_mosi = d[7-i];
      repeat (8) @(negedge clk);
      rx     = {rx[6:0], o_miso};
      oe_all = oe_all & o_miso_oe;
      oe_any = oe_any | o_miso_oe;
      i_sclk = 1'b1;
      repeat (7) @(negedge clk);
    end
  endtask

  task automatic do_read(input logic [7:0] cmd, input int n);
    logic [7:0] rx;
    logic       a, y;
    spi_begin();
    spi_bits(cmd, 8, rx, a, y);
    oe_cmd_any  = y;
    oe_data_all = 1'b1;
    for (int k = 0; k < n; k++) begin
      spi_bits(8'h00, 8, rx, a, y);
      rd_buf[k]   = rx;
      oe_data_all = oe_data_all & a;
    end
    spi_end();
  endtask

  task automatic do_write(input logic [7:0] cmd, input logic [7:0] data);
    logic [7:0] rx;
    logic       a, y;
    spi_begin();
    spi_bits(cmd, 8, rx, a, y);
    spi_bits(data, 8, rx, a, y);
    spi_end();
  endtask

  task automatic host_write(input logic [5:0] a, input logic [7:0] d);
    @(negedge clk);
    i_host_we = 1'b1; i_host_addr = a; i_host_wdata = d;
    @(negedge clk);
    i_host_we = 1'b0;
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    repeat (4) @(negedge clk);
    vectors++; if (o_miso !== 1'b0) begin miscompares++; $display("FAIL reset_miso got %b want 0", o_miso); end
    vectors++; if (o_miso_oe !== 1'b0) begin miscompares++; $display("FAIL reset_oe got %b want 0", o_miso_oe); end
    vectors++; if (o_wr_valid !== 1'b0) begin miscompares++; $display("FAIL reset_wr_valid got %b want 0", o_wr_valid); end
    vectors++; if (o_xfer_done !== 1'b0) begin miscompares++; $display("FAIL reset_xfer_done got %b want 0", o_xfer_done); end
    vectors++; if (o_wr_addr !== 6'h00) begin miscompares++; $display("FAIL reset_wr_addr got %h want 00", o_wr_addr); end
    vectors++; if (o_wr_data !== 8'h00) begin miscompares++; $display("FAIL reset_wr_data got %h want 00", o_wr_data); end
    i_reset = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_read_devid();
    int x0;
    x0 = xfer_cnt;
    do_read(8'h80, 1);
    vectors++; if (rd_buf[0] !== 8'hE5) begin miscompares++; $display("FAIL devid_byte got %h want e5", rd_buf[0]); end
    vectors++; if (oe_cmd_any !== 1'b0) begin miscompares++; $display("FAIL devid_oe_cmd got %b want 0", oe_cmd_any); end
    vectors++; if (oe_data_all !== 1'b1) begin miscompares++; $display("FAIL devid_oe_data got %b want 1", oe_data_all); end
    vectors++; if (o_miso_oe !== 1'b0) begin miscompares++; $display("FAIL devid_oe_after got %b want 0", o_miso_oe); end
    vectors++; if (o_miso !== 1'b0) begin miscompares++; $display("FAIL devid_miso_after got %b want 0", o_miso); end
    vectors++; if (xfer_cnt - x0 !== 1) begin miscompares++; $display("FAIL devid_xfer_done got %0d want 1", xfer_cnt - x0); end
  endtask

  task automatic test_reset_regs();
    do_read(8'h85, 1);
    vectors++; if (rd_buf[0] !== 8'h00) begin miscompares++; $display("FAIL reg05_reset got %h want 00", rd_buf[0]); end
  endtask

  task automatic test_write_read();
    int w0;
    w0 = wr_cnt;
    do_write(8'h2D, 8'h08);
    vectors++; if (wr_cnt - w0 !== 1) begin miscompares++; $display("FAIL wr_pulses got %0d want 1", wr_cnt - w0); end
    vectors++; if (last_wr_addr !== 6'h2D) begin miscompares++; $display("FAIL wr_addr got %h want 2d", last_wr_addr); end
    vectors++; if (last_wr_data !== 8'h08) begin miscompares++; $display("FAIL wr_data got %h want 08", last_wr_data); end
    do_read(8'hAD, 1);
    vectors++; if (rd_buf[0] !== 8'h08) begin miscompares++; $display("FAIL readback_2d got %h want 08", rd_buf[0]); end
  endtask

  task automatic test_burst();
    logic [7:0] exp [6];
`ifdef SPI_SLAVE_AUTOINC_EN
    exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
`else
    exp = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h11, 8'h11};
`endif
    host_write(6'h32, 8'h11);
    host_write(6'h33, 8'h22);
    host_write(6'h34, 8'h33);
    host_write(6'h35, 8'h44);
    host_write(6'h36, 8'h55);
    host_write(6'h37, 8'h66);
    do_read(8'hF2, 6);
    for (int k = 0; k < 6; k++) begin
      vectors++;
      if (rd_buf[k] !== exp[k]) begin
        miscompares++; $display("FAIL burst_byte%0d got %h want %h", k, rd_buf[k], exp[k]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp1;
`ifdef SPI_SLAVE_AUTOINC_EN
    exp1 = 8'hE5;
`else
    exp1 = 8'hAB;
`endif
    host_write(6'h3F, 8'hAB);
    do_read(8'hFF, 2);
    vectors++; if (rd_buf[0] !== 8'hAB) begin miscompares++; $display("FAIL wrap_byte0 got %h want ab", rd_buf[0]); end
    vectors++; if (rd_buf[1] !== exp1) begin miscompares++; $display("FAIL wrap_byte1 got %h want %h", rd_buf[1], exp1); end
  endtask

  task automatic test_partial();
    int         w0, x0;
    logic [7:0] rx;
    logic       a, y;
    w0 = wr_cnt; x0 = xfer_cnt;
    spi_begin();
    spi_bits(8'h31, 8, rx, a, y);
    spi_bits(8'hFF, 5, rx, a, y);
    spi_end();
    vectors++; if (wr_cnt - w0 !== 0) begin miscompares++; $display("FAIL partial_wr_valid got %0d want 0", wr_cnt - w0); end
    vectors++; if (xfer_cnt - x0 !== 1) begin miscompares++; $display("FAIL partial_xfer_done got %0d want 1", xfer_cnt - x0); end
    do_read(8'hB1, 1);
    vectors++; if (rd_buf[0] !== 8'h00) begin miscompares++; $display("FAIL partial_reg31 got %h want 00", rd_buf[0]); end
  endtask

  task automatic test_write_zero();
    int w0;
    w0 = wr_cnt;
    do_write(8'h00, 8'h12);
    vectors++; if (wr_cnt - w0 !== 1) begin miscompares++; $display("FAIL wr0_pulses got %0d want 1", wr_cnt - w0); end
    vectors++; if (last_wr_addr !== 6'h00) begin miscompares++; $display("FAIL wr0_addr got %h want 00", last_wr_addr); end
    do_read(8'h80, 1);
    vectors++; if (rd_buf[0] !== 8'hE5) begin miscompares++; $display("FAIL wr0_devid got %h want e5", rd_buf[0]); end
  endtask

  task automatic test_collision();
    logic [7:0] rx;
    logic       a, y;
    spi_begin();
    spi_bits(8'h2D, 8, rx, a, y);
    spi_bits(8'h08, 7, rx, a, y);
    @(negedge clk);
    i_sclk = 1'b0; i_mosi = 1'b0;
    repeat (8) @(negedge clk);
    i_sclk = 1'b1;                  // commit lands on the third posedge from here
    @(negedge clk);
    @(negedge clk);
    i_host_we = 1'b1; i_host_addr = 6'h2D; i_host_wdata = 8'h55;
    @(negedge clk);
    i_host_we = 1'b0;
    vectors++; if (o_wr_valid !== 1'b1) begin miscompares++; $display("FAIL collide_commit_timing got %b want 1", o_wr_valid); end
    repeat (5) @(negedge clk);
    spi_end();
    do_read(8'hAD, 1);
    vectors++; if (rd_buf[0] !== 8'h08) begin miscompares++; $display("FAIL collide_reg2d got %h want 08", rd_buf[0]); end
  endtask

  task automatic test_reset_mid();
    int         w0;
    logic [7:0] rx;
    logic       a, y;
    spi_begin();
    spi_bits(8'h10, 8, rx, a, y);
    spi_bits(8'hAA, 4, rx, a, y);
    @(negedge clk) i_reset = 1'b1;
    repeat (3) @(negedge clk);
    i_reset = 1'b0;
    w0 = wr_cnt;
    // CS still low: no fresh fall, so these bits must be ignored
    spi_bits(8'h10, 8, rx, a, y);
    spi_bits(8'hAA, 8, rx, a, y);
    vectors++; if (wr_cnt - w0 !== 0) begin miscompares++; $display("FAIL rstmid_no_commit got %0d want 0", wr_cnt - w0); end
    spi_end();
    do_read(8'h90, 1);
    vectors++; if (rd_buf[0] !== 8'h00) begin miscompares++; $display("FAIL rstmid_reg10 got %h want 00", rd_buf[0]); end
    do_read(8'hAD, 1);
    vectors++; if (rd_buf[0] !== 8'h00) begin miscompares++; $display("FAIL rstmid_reg2d_cleared got %h want 00", rd_buf[0]); end
  endtask

  initial begin
    test_reset();
    test_read_devid();
    test_reset_regs();
    test_write_read();
    test_burst();
    test_wrap();
    test_partial();
    test_write_zero();
    test_collision();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_slave_regfile.md
SPI_SLAVE_REGFILE -- requirements
Module: spi_slave_regfile

Interface
REQ-001 Parameter DEVID, default 8'hE5, reset value of register 0x00.
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer depth on SCLK/CS/MOSI (legal 2..3).
REQ-003 clk  input  1  system clock; the only clock; SHALL be at least 8x the SCLK frequency.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 SCLK  input  1  SPI clock, mode 3 (idles high; sample on rising edge, drive on falling edge).
REQ-006 CS  input  1  chip select, active low.
REQ-007 MOSI  input  1  serial data in, MSB first.
REQ-008 MISO  output  1  serial data out, MSB first.
REQ-009 miso_oe  output  1  high while CS low and state is RDATA; pad tristate enable.
REQ-010 host_we  input  1  host-side write strobe into the register file.
REQ-011 host_addr  input  6  host-side register address.
REQ-012 host_wdata  input  8  host-side write data.
REQ-013 wr_valid  output  1  one-cycle pulse when an SPI write commits.
REQ-014 wr_addr  output  6  address of the committed SPI write; valid with wr_valid.
REQ-015 wr_data  output  8  data of the committed SPI write; valid with wr_valid.
REQ-016 xfer_done  output  1  one-cycle pulse on the clk after synchronized CS rises.

Function
REQ-017 SCLK, CS, MOSI SHALL pass SYNC_STAGES flops; edges SHALL be detected from the last two stages, so latency is SYNC_STAGES+1 clk.
REQ-018 States: IDLE, CMD, RDATA, WDATA; IDLE->CMD on the synchronized CS falling edge, with bit counter and shift register cleared.
REQ-019 CMD: shift MOSI in on 8 rising SCLK edges; byte = {RW, MB, ADDR[5:0]}; after the 8th edge, go to RDATA if RW=1, else WDATA.
REQ-020 RDATA: on CMD exit, load the tx shift register with reg[ADDR]; on each falling SCLK edge, MISO = shift MSB, then shift left.
REQ-021 RDATA: after each 8th data bit, ADDR SHALL advance per REQ-031/032 and the shift register SHALL reload from the new ADDR before the next falling edge.
REQ-022 WDATA: shift 8 MOSI bits; on the 8th rising edge, write reg[ADDR] and pulse wr_valid for one clk with wr_addr/wr_data; ADDR advances as in REQ-021.
REQ-023 A synchronized CS rise in any state SHALL return to IDLE next clk, discard any partial byte (no write, no wr_valid), and pulse xfer_done.
REQ-024 Address arithmetic is 6-bit modulo: 0x3F+1 wraps to 0x00.
REQ-025 Writes to address 0x00 SHALL be ignored (read-only DEVID), but wr_valid still pulses.
REQ-026 host_we writes reg[host_addr] on the same clk; if it coincides with an SPI write to the same address, the SPI write wins.
REQ-027 MISO SHALL be 0 whenever miso_oe is 0.

Reset
REQ-028 On reset: state IDLE; MISO, miso_oe, wr_valid, xfer_done = 0; wr_addr = 0, wr_data = 0; synchronizer stages = CS 1, SCLK 1, MOSI 0.
REQ-029 On reset: all registers = 0x00 except reg[0x00] = DEVID.
REQ-030 Reset asserted mid-transfer SHALL abort the transfer with no commit; the next transfer SHALL start only after a fresh CS fall.

Configuration
REQ-031 Macro SPI_SLAVE_AUTOINC_EN defined: with MB=1, ADDR increments after each data byte; with MB=0, ADDR holds.
REQ-032 Macro absent: MB is ignored, ADDR never increments, and repeated bytes read or write the same register.

Structure
REQ-033 Shared package spi_pkg SHALL hold the state enumeration, ADDR_W=6, DATA_W=8, command bit positions (RW=7, MB=6), and the DEVID address constant.
REQ-034 One sub-module, spi_sync_edge: parameterized synchronizer that outputs the synchronized level and rise/fall pulses; instantiated three times.

Verification
REQ-035 Write cmd 0x2D, data 0x08 -> one wr_valid with wr_addr=0x2D, wr_data=0x08; a following read of 0x2D returns 0x08.
REQ-036 Read cmd 0x80 (addr 0x00) -> MISO byte 0xE5; miso_oe high only during the data byte.
REQ-037 Host loads 0x32..0x37 = 0x11..0x66; cmd 0xF2, 48 clocks -> 0x11,0x22,0x33,0x44,0x55,0x66 (macro on) or 0x11 six times (macro off).
REQ-038 Cmd 0xFF, 2 bytes, reg[0x3F]=0xAB -> 0xAB then 0xE5 (wrap to 0x00).
REQ-039 Write cmd 0x31; CS rises after 5 data bits -> no wr_valid, reg[0x31] unchanged, xfer_done pulses once.
REQ-040 host_we to 0x2D with 0x55 on the same clk as an SPI commit of 0x2D=0x08 -> reg[0x2D]=0x08.
